// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard scoreboard.
// Build option: ID_HAZARD_FORWARDING_EN adds the per-slot source fields used
// by the EX operand forwarding logic.
package id_hazard_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 4;

  // EX operand select encodings
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  // One in-flight instruction as seen by the scoreboard
  typedef struct packed {
    logic                  valid;
    logic                  wbEn;
    logic                  memRead;
    logic [REG_ADDR_W-1:0] dest;
`ifdef ID_HAZARD_FORWARDING_EN
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  twoSrc;
`endif
  } sb_entry_t;

  // Empty slot: not valid and never writes back
  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/id_hazard_scoreboard_sb_match.sv
// sb_match: compares two consumer source registers against the destination of
// one scoreboard entry.
// Ports:
//   entry   in  scoreboard entry (producer)
//   src1    in  first consumer source
//   src2    in  second consumer source
//   twoSrc  in  src2 is really read
//   match1  out producer writes src1
//   match2  out producer writes src2 (only when twoSrc)
module sb_match
  import id_hazard_scoreboard_pkg::*;
(
  input  sb_entry_t             entry,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  twoSrc,
  output logic                  match1,
  output logic                  match2
);

  logic producer;

  // Only a live, writing entry can be a producer
  assign producer = entry.valid & entry.wbEn;
  assign match1   = producer & (entry.dest == src1);
  assign match2   = producer & twoSrc & (entry.dest == src2);

endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: tracks the EX/MEM/WB instructions in a shift scoreboard,
// stalls decode on unresolved register dependencies and, when built with
// ID_HAZARD_FORWARDING_EN, drives the EX operand forwarding selects.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   freeze                global pipeline hold; scoreboard and counter hold
//   flush                 instruction in ID is killed (becomes a bubble)
//   idSrc1/idSrc2         sources of the ID instruction, idTwoSrc qualifies idSrc2
//   idDest/idWbEn/idMemRead  destination info of the ID instruction
//   hazard                combinational stall request
//   fwdSel1/fwdSel2       EX operand selects (00 regfile, 01 MEM, 10 WB)
//   stallCount            saturating count of stall cycles
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic [3:0]             idSrc1,
  input  logic [3:0]             idSrc2,
  input  logic                   idTwoSrc,
  input  logic [3:0]             idDest,
  input  logic                   idWbEn,
  input  logic                   idMemRead,
  output logic                   hazard,
  output logic [1:0]             fwdSel1,
  output logic [1:0]             fwdSel2,
  output logic [STALL_CNT_W-1:0] stallCount
);

  sb_entry_t exSlot, memSlot, wbSlot;
  sb_entry_t idEntry;
  logic      exMatch1, exMatch2, memMatch1, memMatch2;
  logic      hazardRaw;

  // Pack the ID instruction into scoreboard form
  always_comb begin
    idEntry         = SB_BUBBLE;
    idEntry.valid   = 1'b1;
    idEntry.wbEn    = idWbEn;
    idEntry.memRead = idMemRead;
    idEntry.dest    = idDest;
`ifdef ID_HAZARD_FORWARDING_EN
    idEntry.src1    = idSrc1;
    idEntry.src2    = idSrc2;
    idEntry.twoSrc  = idTwoSrc;
`endif
  end

  sb_match uExMatch (
    .entry  (exSlot),
    .src1   (idSrc1),
    .src2   (idSrc2),
    .twoSrc (idTwoSrc),
    .match1 (exMatch1),
    .match2 (exMatch2)
  );

  sb_match uMemMatch (
    .entry  (memSlot),
    .src1   (idSrc1),
    .src2   (idSrc2),
    .twoSrc (idTwoSrc),
    .match1 (memMatch1),
    .match2 (memMatch2)
  );

`ifdef ID_HAZARD_FORWARDING_EN
  logic fwdMem1, fwdMem2, fwdWb1, fwdWb2;

  // Only a load still in EX cannot be forwarded in time; MEM match is bypassed
  assign hazardRaw = (exMatch1 | exMatch2) & exSlot.memRead;

  // Forwarding looks at the EX instruction's own operands, registered only
  sb_match uFwdMem (
    .entry  (memSlot),
    .src1   (exSlot.src1),
    .src2   (exSlot.src2),
    .twoSrc (exSlot.twoSrc),
    .match1 (fwdMem1),
    .match2 (fwdMem2)
  );

  sb_match uFwdWb (
    .entry  (wbSlot),
    .src1   (exSlot.src1),
    .src2   (exSlot.src2),
    .twoSrc (exSlot.twoSrc),
    .match1 (fwdWb1),
    .match2 (fwdWb2)
  );

  // MEM holds the younger value, so it wins over WB
  always_comb begin
    fwdSel1 = FWD_REGFILE;
    fwdSel2 = FWD_REGFILE;
    if (fwdMem1)     fwdSel1 = FWD_MEM;
    else if (fwdWb1) fwdSel1 = FWD_WB;
    if (fwdMem2)     fwdSel2 = FWD_MEM;
    else if (fwdWb2) fwdSel2 = FWD_WB;
  end
`else
  logic unusedMatch;

  // No bypass: any producer in EX or MEM must drain to WB first
  assign hazardRaw   = exMatch1 | exMatch2 | memMatch1 | memMatch2;
  assign fwdSel1     = FWD_REGFILE;
  assign fwdSel2     = FWD_REGFILE;
  assign unusedMatch = ^wbSlot;
`endif

  // A killed ID instruction cannot stall anything
  assign hazard = hazardRaw & ~flush;

  // Scoreboard shift: ID -> EX -> MEM -> WB, bubbles on stall or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exSlot  <= SB_BUBBLE;
      memSlot <= SB_BUBBLE;
      wbSlot  <= SB_BUBBLE;
    end else if (!freeze) begin
      exSlot  <= (hazard | flush) ? SB_BUBBLE : idEntry;
      memSlot <= exSlot;
      wbSlot  <= memSlot;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
    end else if (!freeze && hazard && (stallCount != {STALL_CNT_W{1'b1}})) begin
      stallCount <= stallCount + STALL_CNT_W'(1);
    end
  end

endmodule
